// File: rtl/mdu_hilo_unit.sv
// mdu_hilo_unit: multi-cycle multiply/divide unit that owns the HI/LO registers.
//
// Multiplies run through a MUL_LAT-deep product pipeline. Divides use a radix-2
// restoring divider, followed by one sign-fix cycle. Accumulating ops read HI/LO
// in their writeback cycle. MTHI/MTLO can write HI/LO in any cycle, but an op
// writeback to the same register takes priority.
//
// Ports:
//   clk, resetn        clock (rising edge), asynchronous active-low reset
//   valid_i / ready_o  op request / unit idle; accept = valid_i & ready_o & !flush_i
//   op_i               0 MULT, 1 MULTU, 2 MADD, 3 MADDU, 4 MSUB, 5 MSUBU, 6 DIV, 7 DIVU
//   a_i, b_i           operands, sampled at accept
//   flush_i            abort the in-flight op; no writeback, no done
//   wr_hi_i, wr_lo_i   MTHI/MTLO strobes carrying wdata_i
//   busy_o, done_o     op in flight / one-cycle pulse when an op writes HI/LO
//   hi_o, lo_o         registered HI/LO contents

module mdu_hilo_unit #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned MUL_LAT = 2
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             flush_i,
   input  logic             wr_hi_i,
   input  logic             wr_lo_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int unsigned     CntW    = $clog2(WIDTH + 1);
   localparam logic [CntW-1:0] MulLast = CntW'(MUL_LAT - 1);
   localparam logic [CntW-1:0] DivLast = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

   state_e              state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]    hi_q, hi_d, lo_q, lo_d;

   logic                accept, op_signed, a_neg, b_neg;
   logic [WIDTH-1:0]    a_mag, b_mag;

   logic [1:0]          mode_q;      // op_i[2:1]: 0 plain, 1 add, 2 subtract
   logic                neg_q;       // operand signs differ (product / quotient)
   logic                rem_neg_q;   // dividend was negative
   logic                div0_q;
   logic [WIDTH-1:0]    dividend_q;  // raw dividend, returned as HI on divide by zero
   logic [WIDTH-1:0]    divisor_q, quo_q, rem_q;
   logic [2*WIDTH-1:0]  prod_q [MUL_LAT];

   logic [WIDTH:0]      rem_shift, rem_diff;
   logic [2*WIDTH-1:0]  acc, prod_signed, mul_res;
   logic [WIDTH-1:0]    quo_fix, rem_fix;
   logic                wb_mul, wb_div;

   assign ready_o = (state_q == StIdle);
   assign busy_o  = !ready_o;
   assign done_o  = wb_mul | wb_div;
   assign hi_o    = hi_q;
   assign lo_o    = lo_q;

   assign accept    = valid_i && ready_o && !flush_i;
   // Signed ops are the even encodings.
   assign op_signed = !op_i[0];
   assign a_neg     = op_signed & a_i[WIDTH-1];
   assign b_neg     = op_signed & b_i[WIDTH-1];
   assign a_mag     = a_neg ? -a_i : a_i;
   assign b_mag     = b_neg ? -b_i : b_i;

   // One restoring step. The dividend shifts out of quo_q MSB first while the
   // quotient bits shift into its LSB.
   assign rem_shift = {rem_q, quo_q[WIDTH-1]};
   assign rem_diff  = rem_shift - {1'b0, divisor_q};

   assign acc         = {hi_q, lo_q};
   assign prod_signed = neg_q ? -prod_q[MUL_LAT-1] : prod_q[MUL_LAT-1];
   assign quo_fix     = neg_q ? -quo_q : quo_q;
   assign rem_fix     = rem_neg_q ? -rem_q : rem_q;

   always_comb begin
      mul_res = prod_signed;
      case (mode_q)
         2'd1:    mul_res = acc + prod_signed;
         2'd2:    mul_res = acc - prod_signed;
         default: mul_res = prod_signed;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wb_mul  = 1'b0;
      wb_div  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = (op_i[2] && op_i[1]) ? StDiv : StMul;
               cnt_d   = '0;
            end
         end
         StMul: begin
            if (flush_i) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (cnt_q == MulLast) begin
               wb_mul  = 1'b1;
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDiv: begin
            if (flush_i) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (cnt_q == DivLast) begin
               state_d = StFix;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StFix: begin
            state_d = StIdle;
            cnt_d   = '0;
            wb_div  = !flush_i;
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   // The op writeback is applied last so that it overrides a coincident MTHI/MTLO.
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (wr_hi_i) hi_d = wdata_i;
      if (wr_lo_i) lo_d = wdata_i;
      if (wb_mul) begin
         hi_d = mul_res[2*WIDTH-1:WIDTH];
         lo_d = mul_res[WIDTH-1:0];
      end else if (wb_div) begin
         if (div0_q) begin
            hi_d = dividend_q;
            lo_d = '1;
         end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mode_q     <= '0;
         neg_q      <= 1'b0;
         rem_neg_q  <= 1'b0;
         div0_q     <= 1'b0;
         dividend_q <= '0;
         divisor_q  <= '0;
         quo_q      <= '0;
         rem_q      <= '0;
         for (int i = 0; i < MUL_LAT; i++) prod_q[i] <= '0;
      end else begin
         if (accept) begin
            mode_q     <= op_i[2:1];
            neg_q      <= a_neg ^ b_neg;
            rem_neg_q  <= a_neg;
            div0_q     <= (b_i == '0);
            dividend_q <= a_i;
            divisor_q  <= b_mag;
            quo_q      <= a_mag;
            rem_q      <= '0;
            prod_q[0]  <= (2*WIDTH)'(a_mag) * (2*WIDTH)'(b_mag);
         end else if (state_q == StDiv) begin
            quo_q <= {quo_q[WIDTH-2:0], !rem_diff[WIDTH]};
            rem_q <= rem_diff[WIDTH] ? rem_shift[WIDTH-1:0] : rem_diff[WIDTH-1:0];
         end
         for (int i = 1; i < MUL_LAT; i++) prod_q[i] <= prod_q[i-1];
      end
   end

endmodule

// File: tb/tb_mdu_hilo_unit.sv
// Directed testbench for mdu_hilo_unit (WIDTH=32, MUL_LAT=2).
module tb_mdu_hilo_unit;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        valid_i = 1'b0;
   logic        ready_o;
   logic [2:0]  op_i = '0;
   logic [31:0] a_i = '0;
   logic [31:0] b_i = '0;
   logic        flush_i = 1'b0;
   logic        wr_hi_i = 1'b0;
   logic        wr_lo_i = 1'b0;
   logic [31:0] wdata_i = '0;
   logic        busy_o;
   logic        done_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   int checks = 0;
   int errors = 0;

   mdu_hilo_unit #(.WIDTH(32), .MUL_LAT(2)) dut (
      .clk     (clk),
      .resetn  (resetn),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .op_i    (op_i),
      .a_i     (a_i),
      .b_i     (b_i),
      .flush_i (flush_i),
      .wr_hi_i (wr_hi_i),
      .wr_lo_i (wr_lo_i),
      .wdata_i (wdata_i),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .hi_o    (hi_o),
      .lo_o    (lo_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Handshake edge ends cycle T; returns 1 ns into cycle T+1.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      valid_i = 1'b1; op_i = op; a_i = a; b_i = b;
      @(posedge clk);
      #1 valid_i = 1'b0;
   endtask

   // Called right after issue(); lat = k when done_o is seen in cycle T+k, 0 on timeout.
   task automatic wait_done(output int lat);
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (done_o) begin
            lat = k;
            break;
         end
         @(posedge clk);
      end
   endtask

   task automatic mt(input logic hi, input logic lo, input logic [31:0] d);
      @(negedge clk);
      wr_hi_i = hi; wr_lo_i = lo; wdata_i = d;
      @(negedge clk);
      wr_hi_i = 1'b0; wr_lo_i = 1'b0;
   endtask

   task automatic test_reset;
      @(negedge clk);
      checks++; if (hi_o !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h exp=0", hi_o); end
      checks++; if (lo_o !== 32'h0) begin errors++; $display("FAIL reset_lo got=%h exp=0", lo_o); end
      checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
      resetn = 1'b1;
   endtask

   task automatic test_mult;
      issue(3'd0, 32'hFFFF_FFFE, 32'd3);
      @(negedge clk); // T+1
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL mult_busy got=%b exp=1", busy_o); end
      checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL mult_early_done got=%b exp=0", done_o); end
      @(negedge clk); // T+2
      checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL mult_done got=%b exp=1", done_o); end
      checks++; if (hi_o !== 32'h0) begin errors++; $display("FAIL mult_no_bypass got=%h exp=0", hi_o); end
      @(negedge clk); // T+3
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL mult_ready got=%b exp=1", ready_o); end
      checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL mult_done_pulse got=%b exp=0", done_o); end
      checks++; if (hi_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got=%h exp=ffffffff", hi_o); end
      checks++; if (lo_o !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo got=%h exp=fffffffa", lo_o); end
   endtask

   task automatic test_accumulate;
      int lat;
      mt(1'b1, 1'b0, 32'h0);
      mt(1'b0, 1'b1, 32'hFFFF_FFFF);
      checks++; if (lo_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mtlo got=%h exp=ffffffff", lo_o); end
      issue(3'd3, 32'd1, 32'd1);
      wait_done(lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL maddu_lat got=%0d exp=2", lat); end
      @(negedge clk);
      checks++; if (hi_o !== 32'h1) begin errors++; $display("FAIL maddu_hi got=%h exp=1", hi_o); end
      checks++; if (lo_o !== 32'h0) begin errors++; $display("FAIL maddu_lo got=%h exp=0", lo_o); end
      issue(3'd4, 32'd2, 32'hFFFF_FFFD);
      wait_done(lat);
      @(negedge clk);
      checks++; if (hi_o !== 32'h1) begin errors++; $display("FAIL msub_hi got=%h exp=1", hi_o); end
      checks++; if (lo_o !== 32'h6) begin errors++; $display("FAIL msub_lo got=%h exp=6", lo_o); end
      // MTHI while the MADDU is in flight feeds the accumulation.
      mt(1'b1, 1'b1, 32'h0);
      issue(3'd3, 32'd1, 32'd1);
      wr_hi_i = 1'b1; wdata_i = 32'd5;
      @(posedge clk);
      #1 wr_hi_i = 1'b0;
      @(negedge clk); // T+2
      checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL madd_mthi_done got=%b exp=1", done_o); end
      @(negedge clk);
      checks++; if (hi_o !== 32'd5) begin errors++; $display("FAIL madd_mthi_hi got=%h exp=5", hi_o); end
      checks++; if (lo_o !== 32'd1) begin errors++; $display("FAIL madd_mthi_lo got=%h exp=1", lo_o); end
   endtask

   task automatic test_div_signed;
      int lat;
      issue(3'd6, 32'hFFFF_FFF9, 32'd2);
      wait_done(lat);
      checks++; if (lat !== 33) begin errors++; $display("FAIL div_lat got=%0d exp=33", lat); end
      @(negedge clk);
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL div_ready got=%b exp=1", ready_o); end
      checks++; if (lo_o !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got=%h exp=fffffffd", lo_o); end
      checks++; if (hi_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got=%h exp=ffffffff", hi_o); end
      issue(3'd6, 32'd7, 32'hFFFF_FFFE);
      wait_done(lat);
      @(negedge clk);
      checks++; if (lo_o !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_pn_lo got=%h exp=fffffffd", lo_o); end
      checks++; if (hi_o !== 32'h1) begin errors++; $display("FAIL div_pn_hi got=%h exp=1", hi_o); end
      issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(lat);
      @(negedge clk);
      checks++; if (lo_o !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo got=%h exp=80000000", lo_o); end
      checks++; if (hi_o !== 32'h0) begin errors++; $display("FAIL div_ovf_hi got=%h exp=0", hi_o); end
   endtask

   task automatic test_div_zero;
      int lat;
      issue(3'd7, 32'd5, 32'd0);
      wait_done(lat);
      checks++; if (lat !== 33) begin errors++; $display("FAIL divz_lat got=%0d exp=33", lat); end
      @(negedge clk);
      checks++; if (lo_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divuz_lo got=%h exp=ffffffff", lo_o); end
      checks++; if (hi_o !== 32'd5) begin errors++; $display("FAIL divuz_hi got=%h exp=5", hi_o); end
      issue(3'd6, 32'hFFFF_FFFB, 32'd0);
      wait_done(lat);
      @(negedge clk);
      checks++; if (lo_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divz_lo got=%h exp=ffffffff", lo_o); end
      checks++; if (hi_o !== 32'hFFFF_FFFB) begin errors++; $display("FAIL divz_hi got=%h exp=fffffffb", hi_o); end
   endtask

   task automatic test_flush;
      logic saw_done;
      mt(1'b1, 1'b0, 32'hAAAA);
      mt(1'b0, 1'b1, 32'h5555);
      issue(3'd7, 32'd100, 32'd3);
      repeat (10) @(negedge clk); // T+10
      flush_i = 1'b1; wr_lo_i = 1'b1; wdata_i = 32'h77;
      @(posedge clk);
      #1 flush_i = 1'b0; wr_lo_i = 1'b0;
      @(negedge clk); // T+11
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b exp=1", ready_o); end
      checks++; if (hi_o !== 32'hAAAA) begin errors++; $display("FAIL flush_hi got=%h exp=aaaa", hi_o); end
      checks++; if (lo_o !== 32'h77) begin errors++; $display("FAIL flush_mtlo got=%h exp=77", lo_o); end
      saw_done = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (done_o) saw_done = 1'b1;
      end
      checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL flush_no_done got=%b exp=0", saw_done); end
      // Flush landing exactly on the multiply writeback cycle.
      issue(3'd1, 32'd3, 32'd3);
      @(negedge clk); // T+1
      @(negedge clk); // T+2
      flush_i = 1'b1;
      #1;
      checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL flush_wb_done got=%b exp=0", done_o); end
      @(posedge clk);
      #1 flush_i = 1'b0;
      @(negedge clk);
      checks++; if (lo_o !== 32'h77) begin errors++; $display("FAIL flush_wb_lo got=%h exp=77", lo_o); end
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL flush_wb_ready got=%b exp=1", ready_o); end
   endtask

   task automatic test_flush_idle;
      logic saw_done;
      @(negedge clk);
      valid_i = 1'b1; op_i = 3'd1; a_i = 32'd2; b_i = 32'd2; flush_i = 1'b1;
      @(posedge clk);
      #1 valid_i = 1'b0; flush_i = 1'b0;
      @(negedge clk);
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL flush_idle_busy got=%b exp=0", busy_o); end
      saw_done = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (done_o) saw_done = 1'b1;
      end
      checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL flush_idle_done got=%b exp=0", saw_done); end
      checks++; if (lo_o !== 32'h77) begin errors++; $display("FAIL flush_idle_lo got=%h exp=77", lo_o); end
   endtask

   task automatic test_collision;
      int lat;
      mt(1'b1, 1'b1, 32'h0);
      issue(3'd1, 32'h8000_0000, 32'd4);
      @(negedge clk); // T+1
      @(negedge clk); // T+2
      checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL coll_done got=%b exp=1", done_o); end
      wr_hi_i = 1'b1; wdata_i = 32'h1234;
      @(posedge clk);
      #1 wr_hi_i = 1'b0;
      @(negedge clk);
      checks++; if (hi_o !== 32'd2) begin errors++; $display("FAIL coll_hi got=%h exp=2", hi_o); end
      checks++; if (lo_o !== 32'd0) begin errors++; $display("FAIL coll_lo got=%h exp=0", lo_o); end
      // MTLO mid-divide is visible immediately, then replaced by the quotient.
      issue(3'd7, 32'd100, 32'd7);
      repeat (5) @(negedge clk);
      wr_lo_i = 1'b1; wdata_i = 32'hDEAD;
      @(posedge clk);
      #1 wr_lo_i = 1'b0;
      @(negedge clk);
      checks++; if (lo_o !== 32'hDEAD) begin errors++; $display("FAIL mtlo_div got=%h exp=dead", lo_o); end
      wait_done(lat);
      checks++; if (lat == 0) begin errors++; $display("FAIL mtlo_div_timeout got=%0d exp=nonzero", lat); end
      @(negedge clk);
      checks++; if (lo_o !== 32'd14) begin errors++; $display("FAIL mtlo_div_lo got=%h exp=e", lo_o); end
      checks++; if (hi_o !== 32'd2) begin errors++; $display("FAIL mtlo_div_hi got=%h exp=2", hi_o); end
   endtask

   task automatic test_reset_mid_div;
      int lat;
      issue(3'd6, 32'd1000, 32'd3);
      repeat (5) @(negedge clk);
      resetn = 1'b0;
      #1;
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy_o); end
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%b exp=1", ready_o); end
      checks++; if (hi_o !== 32'h0) begin errors++; $display("FAIL rst_mid_hi got=%h exp=0", hi_o); end
      checks++; if (lo_o !== 32'h0) begin errors++; $display("FAIL rst_mid_lo got=%h exp=0", lo_o); end
      checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL rst_mid_done got=%b exp=0", done_o); end
      @(negedge clk);
      resetn = 1'b1;
      issue(3'd1, 32'd3, 32'd5);
      wait_done(lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL post_rst_lat got=%0d exp=2", lat); end
      @(negedge clk);
      checks++; if (lo_o !== 32'd15) begin errors++; $display("FAIL post_rst_lo got=%h exp=f", lo_o); end
   endtask

   initial begin
      test_reset;
      test_mult;
      test_accumulate;
      test_div_signed;
      test_div_zero;
      test_flush;
      test_flush_idle;
      test_collision;
      test_reset_mid_div;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
